// File: rtl/placar_display.sv
// ============================================================================
// Module   : placar_display
// Purpose  : Scoreboard for a battleship-style game. Counts hits (acertos)
//            and remaining shots (restantes) as 2-digit BCD, tracks the
//            game outcome, and drives a 4-digit multiplexed 7-segment
//            display (active-low).
// Ports    : clock      - system clock, rising edge
//            reset      - asynchronous active-high reset
//            enable     - high while the game is in its attack phase
//            tiro       - one-clock pulse for a confirmed attack
//            acerto     - hit flag, only looked at while tiro is high
//            digito     - active-low digit selects, bit0 = rightmost digit
//            segmentos  - active-low segments, bit6 = a .. bit0 = g
//            dp         - active-low decimal point
//            fim_jogo   - high in VITORIA or DERROTA
//            vitoria    - high only in VITORIA
// Options  : PISCAR_FIM_EN - when defined, the display blinks in the end
//            states using an extended scan counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module placar_display #(
   parameter int MAX_TIROS   = 15,
   parameter int TOTAL_ALVOS = 8,
   parameter int DIV_BITS    = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       tiro,
   input  logic       acerto,
   output logic [3:0] digito,
   output logic [6:0] segmentos,
   output logic       dp,
   output logic       fim_jogo,
   output logic       vitoria
);

   localparam logic [3:0] c_max_t = 4'(MAX_TIROS / 10);
   localparam logic [3:0] c_max_u = 4'(MAX_TIROS % 10);
   localparam logic [3:0] c_alv_t = 4'(TOTAL_ALVOS / 10);
   localparam logic [3:0] c_alv_u = 4'(TOTAL_ALVOS % 10);

`ifdef PISCAR_FIM_EN
   // Six extra bits above the digit select provide the blink period.
   localparam int c_scan_w = DIV_BITS + 8;
`else
   localparam int c_scan_w = DIV_BITS + 2;
`endif

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      JOGANDO = 2'd1,
      VITORIA = 2'd2,
      DERROTA = 2'd3
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [3:0]           r_ac_t, r_ac_u, r_re_t, r_re_u;
   logic [3:0]           w_ac_t_nxt, w_ac_u_nxt, w_re_t_nxt, w_re_u_nxt;
   logic [3:0]           w_inc_t, w_inc_u, w_dec_t, w_dec_u;
   logic [c_scan_w-1:0]  r_scan;
   logic                 r_fim, r_vit;
   logic [1:0]           w_sel;
   logic [3:0]           w_val;
   logic [6:0]           w_seg;
   logic                 w_blank;

   // BCD increment of acertos and decrement of restantes
   always_comb begin
      w_inc_t = r_ac_t;
      w_inc_u = r_ac_u + 4'd1;
      if (r_ac_u == 4'd9) begin
         w_inc_u = 4'd0;
         w_inc_t = r_ac_t + 4'd1;
      end
      w_dec_t = r_re_t;
      w_dec_u = r_re_u - 4'd1;
      if (r_re_u == 4'd0) begin
         w_dec_u = 4'd9;
         w_dec_t = r_re_t - 4'd1;
      end
   end

   // Next-state and next-counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_ac_t_nxt  = r_ac_t;
      w_ac_u_nxt  = r_ac_u;
      w_re_t_nxt  = r_re_t;
      w_re_u_nxt  = r_re_u;
      if (!enable) begin
         w_state_nxt = OCIOSO;
      end else begin
         case (r_state)
            OCIOSO: begin
               w_state_nxt = JOGANDO;
               w_ac_t_nxt  = 4'd0;
               w_ac_u_nxt  = 4'd0;
               w_re_t_nxt  = c_max_t;
               w_re_u_nxt  = c_max_u;
            end
            JOGANDO: begin
               if (tiro) begin
                  w_re_t_nxt = w_dec_t;
                  w_re_u_nxt = w_dec_u;
                  if (acerto) begin
                     w_ac_t_nxt = w_inc_t;
                     w_ac_u_nxt = w_inc_u;
                  end
                  // Victory is tested first so it wins on the last shot.
                  if ((w_ac_t_nxt == c_alv_t) && (w_ac_u_nxt == c_alv_u))
                     w_state_nxt = VITORIA;
                  else if ((w_re_t_nxt == 4'd0) && (w_re_u_nxt == 4'd0))
                     w_state_nxt = DERROTA;
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= OCIOSO;
         r_ac_t  <= 4'd0;
         r_ac_u  <= 4'd0;
         r_re_t  <= 4'd0;
         r_re_u  <= 4'd0;
         r_scan  <= '0;
         r_fim   <= 1'b0;
         r_vit   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ac_t  <= w_ac_t_nxt;
         r_ac_u  <= w_ac_u_nxt;
         r_re_t  <= w_re_t_nxt;
         r_re_u  <= w_re_u_nxt;
         r_scan  <= r_scan + 1'b1;
         // Decoded from the next state so the flags line up with r_state.
         r_fim   <= (w_state_nxt == VITORIA) || (w_state_nxt == DERROTA);
         r_vit   <= (w_state_nxt == VITORIA);
      end
   end

   assign fim_jogo = r_fim;
   assign vitoria  = r_vit;

   // Display multiplexing, decoded from registered state only
   assign w_sel = r_scan[DIV_BITS+1:DIV_BITS];

   always_comb begin
      w_blank = (r_state == OCIOSO);
`ifdef PISCAR_FIM_EN
      if (((r_state == VITORIA) || (r_state == DERROTA)) && r_scan[DIV_BITS+7])
         w_blank = 1'b1;
`endif
   end

   always_comb begin
      case (w_sel)
         2'd0:    w_val = r_re_u;
         2'd1:    w_val = r_re_t;
         2'd2:    w_val = r_ac_u;
         default: w_val = r_ac_t;
      endcase
   end

   always_comb begin
      case (w_val)
         4'd0:    w_seg = 7'b0000001;
         4'd1:    w_seg = 7'b1001111;
         4'd2:    w_seg = 7'b0010010;
         4'd3:    w_seg = 7'b0000110;
         4'd4:    w_seg = 7'b1001100;
         4'd5:    w_seg = 7'b0100100;
         4'd6:    w_seg = 7'b0100000;
         4'd7:    w_seg = 7'b0001111;
         4'd8:    w_seg = 7'b0000000;
         4'd9:    w_seg = 7'b0000100;
         default: w_seg = 7'b1111111;
      endcase
   end

   always_comb begin
      digito    = 4'b1111;
      segmentos = 7'b1111111;
      dp        = 1'b1;
      if (!w_blank) begin
         digito    = ~(4'b0001 << w_sel);
         segmentos = w_seg;
         dp        = ~(r_state == VITORIA);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_placar_display.sv
// ============================================================================
// Module   : tb_placar_display
// Purpose  : Self-checking bench for placar_display. Four instances with
//            different game parameters (all with a short scan period) are
//            driven from a vector table and a few hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_placar_display;

   typedef struct {
      int         d;
      logic       t;
      logic       a;
      logic [7:0] ea;
      logic [7:0] er;
      logic       ef;
      logic       ev;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       tiro   [4];
   logic       acerto [4];
   logic [3:0] digito [4];
   logic [6:0] segs   [4];
   logic       dp     [4];
   logic       fim    [4];
   logic       vit    [4];

   int   total = 0;
   int   bad   = 0;
   vec_t tbl[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   placar_display #(.MAX_TIROS(15), .TOTAL_ALVOS(8), .DIV_BITS(2)) u0 (
      .clock(clk), .reset(rst), .enable(en), .tiro(tiro[0]), .acerto(acerto[0]),
      .digito(digito[0]), .segmentos(segs[0]), .dp(dp[0]),
      .fim_jogo(fim[0]), .vitoria(vit[0]));
   placar_display #(.MAX_TIROS(2), .TOTAL_ALVOS(2), .DIV_BITS(2)) u1 (
      .clock(clk), .reset(rst), .enable(en), .tiro(tiro[1]), .acerto(acerto[1]),
      .digito(digito[1]), .segmentos(segs[1]), .dp(dp[1]),
      .fim_jogo(fim[1]), .vitoria(vit[1]));
   placar_display #(.MAX_TIROS(1), .TOTAL_ALVOS(1), .DIV_BITS(2)) u2 (
      .clock(clk), .reset(rst), .enable(en), .tiro(tiro[2]), .acerto(acerto[2]),
      .digito(digito[2]), .segmentos(segs[2]), .dp(dp[2]),
      .fim_jogo(fim[2]), .vitoria(vit[2]));
   placar_display #(.MAX_TIROS(12), .TOTAL_ALVOS(11), .DIV_BITS(2)) u3 (
      .clock(clk), .reset(rst), .enable(en), .tiro(tiro[3]), .acerto(acerto[3]),
      .digito(digito[3]), .segmentos(segs[3]), .dp(dp[3]),
      .fim_jogo(fim[3]), .vitoria(vit[3]));

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [7:0] bcd(input int n);
      return 8'(((n / 10) << 4) | (n % 10));
   endfunction

   function automatic vec_t mk(input int d, input logic t, input logic a,
                               input logic [7:0] ea, input logic [7:0] er,
                               input logic ef, input logic ev);
      vec_t v;
      v.d = d; v.t = t; v.a = a; v.ea = ea; v.er = er; v.ef = ef; v.ev = ev;
      return v;
   endfunction

   // Scans 16 cycles (one full display period) and checks every active digit.
   task automatic check_disp(input int d, input logic [15:0] exp_digits,
                             input logic exp_dp, input string nm);
      logic [3:0] seen;
      logic [3:0] pat;
      logic [3:0] dv;
      int         k;
      seen = 4'b0000;
      for (int c = 0; c < 16; c++) begin
         k = -1;
         for (int b = 0; b < 4; b++) begin
            pat = 4'b0001 << b;
            pat = ~pat;
            if (digito[d] === pat) k = b;
         end
         total++;
         if (k < 0) begin
            bad++;
            $display("FAIL %s dut%0d digito=%b is not a single active-low select", nm, d, digito[d]);
         end else begin
            dv = exp_digits[4*k +: 4];
            seen[k] = 1'b1;
            if (segs[d] !== seg7(dv) || dp[d] !== exp_dp) begin
               bad++;
               $display("FAIL %s dut%0d digit%0d seg=%b dp=%b expected seg=%b dp=%b",
                        nm, d, k, segs[d], dp[d], seg7(dv), exp_dp);
            end
         end
         @(negedge clk);
      end
      total++;
      if (seen !== 4'b1111) begin
         bad++;
         $display("FAIL %s dut%0d digits seen=%b expected 1111", nm, d, seen);
      end
   endtask

   task automatic check_blank(input int d, input string nm);
      total++;
      if (digito[d] !== 4'b1111 || segs[d] !== 7'b1111111 || dp[d] !== 1'b1) begin
         bad++;
         $display("FAIL %s dut%0d digito=%b seg=%b dp=%b expected 1111/1111111/1",
                  nm, d, digito[d], segs[d], dp[d]);
      end
   endtask

   task automatic check_flags(input int d, input logic ef, input logic ev, input string nm);
      total++;
      if (fim[d] !== ef || vit[d] !== ev) begin
         bad++;
         $display("FAIL %s dut%0d fim=%b vit=%b expected fim=%b vit=%b",
                  nm, d, fim[d], vit[d], ef, ev);
      end
   endtask

   // Drive one record, queue its expectation, compare once the DUT responds.
   task automatic apply(input vec_t v, input string nm);
      vec_t e;
      tiro[v.d]   = v.t;
      acerto[v.d] = v.a;
      sb.push_back(v);
      @(negedge clk);
      tiro[v.d]   = 1'b0;
      acerto[v.d] = 1'b0;
      e = sb.pop_front();
      check_flags(e.d, e.ef, e.ev, nm);
      check_disp(e.d, {e.ea, e.er}, ~e.ev, nm);
   endtask

   initial begin
      logic [3:0] prev;
      logic [3:0] pat;
      bit         found;

      // Vector table
      tbl.push_back(mk(0, 1, 1, 8'h01, 8'h14, 0, 0));
      tbl.push_back(mk(0, 1, 0, 8'h01, 8'h13, 0, 0));
      tbl.push_back(mk(0, 1, 1, 8'h02, 8'h12, 0, 0));
      tbl.push_back(mk(0, 0, 1, 8'h02, 8'h12, 0, 0));
      tbl.push_back(mk(1, 1, 1, 8'h01, 8'h01, 0, 0));
      tbl.push_back(mk(1, 1, 1, 8'h02, 8'h00, 1, 1));
      tbl.push_back(mk(1, 1, 1, 8'h02, 8'h00, 1, 1));
      tbl.push_back(mk(1, 1, 0, 8'h02, 8'h00, 1, 1));
      tbl.push_back(mk(2, 1, 1, 8'h01, 8'h00, 1, 1));
      for (int i = 1; i <= 10; i++)
         tbl.push_back(mk(3, 1, 1, bcd(i), bcd(12 - i), 0, 0));
      tbl.push_back(mk(3, 0, 1, 8'h10, 8'h02, 0, 0));
      tbl.push_back(mk(3, 1, 1, 8'h11, 8'h01, 1, 1));

      for (int i = 0; i < 4; i++) begin
         tiro[i]   = 1'b0;
         acerto[i] = 1'b0;
      end
      rst = 1'b1;
      en  = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check_blank(i, "reset_blank");
         check_flags(i, 1'b0, 1'b0, "reset_flags");
      end
      rst = 1'b0;
      @(negedge clk);
      check_disp(0, 16'h0015, 1'b1, "start_0015");
      check_disp(1, 16'h0002, 1'b1, "start_0002");
      check_disp(2, 16'h0001, 1'b1, "start_0001");
      check_disp(3, 16'h0012, 1'b1, "start_0012");

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // Mid-game reset discards the game; no restart without enable.
      en  = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_blank(0, "reset_midgame");
      check_flags(1, 1'b0, 1'b0, "reset_midgame_flags");
      en = 1'b1;
      @(negedge clk);
      check_disp(0, 16'h0015, 1'b1, "restart_0015");

      apply(mk(2, 1, 0, 8'h00, 8'h00, 1, 0), "derrota_last_shot");
      for (int i = 1; i <= 6; i++)
         apply(mk(0, 1, 0, 8'h00, bcd(15 - i), 0, 0), $sformatf("borrow_miss%0d", i));

      // Digit scan order
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         prev = digito[0];
         @(negedge clk);
         if (digito[0] === 4'b1110 && prev !== 4'b1110) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL scan_align digito=%b never entered 1110", digito[0]);
      end
      for (int c = 0; c < 16; c++) begin
         pat = 4'b0001 << (c / 4);
         pat = ~pat;
         total++;
         if (digito[0] !== pat) begin
            bad++;
            $display("FAIL scan_order cycle%0d digito=%b expected %b", c, digito[0], pat);
         end
         @(negedge clk);
      end

      // enable low blanks on the next clock; enable high reloads
      en = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) check_blank(i, "enable_off");
      check_flags(2, 1'b0, 1'b0, "enable_off_flags");
      en = 1'b1;
      @(negedge clk);
      check_flags(2, 1'b0, 1'b0, "reload_flags");
      check_disp(0, 16'h0015, 1'b1, "reload_0015");
      check_disp(2, 16'h0001, 1'b1, "reload_0001");

`ifdef PISCAR_FIM_EN
      apply(mk(2, 1, 0, 8'h00, 8'h00, 1, 0), "blink_derrota");
      found = 1'b0;
      for (int c = 0; c < 1100 && !found; c++) begin
         prev = digito[2];
         @(negedge clk);
         if (digito[2] === 4'b1111 && prev !== 4'b1111) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL blink_align display never blanked");
      end else begin
         int nb = 0;
         int ns = 0;
         for (int c = 0; c < 512; c++) begin
            if (digito[2] !== 4'b1111) nb++;
            @(negedge clk);
         end
         for (int c = 0; c < 512; c++) begin
            if (digito[2] === 4'b1111) ns++;
            @(negedge clk);
         end
         total++;
         if (nb != 0 || ns != 0) begin
            bad++;
            $display("FAIL blink_window shown_in_blank=%0d blank_in_shown=%0d expected 0/0", nb, ns);
         end
         check_flags(2, 1'b1, 1'b0, "blink_flags");
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/placar_display.md
PLACAR_DISPLAY -- requirements
Module: placar_display

Interface
REQ-001 SHALL have parameter MAX_TIROS, default 15: shots allowed per game, legal range 1..99.
REQ-002 SHALL have parameter TOTAL_ALVOS, default 8: ship cells to sink for victory, legal range 1..99.
REQ-003 SHALL have parameter DIV_BITS, default 15: digit scan period is 2^DIV_BITS clocks.
REQ-004 SHALL have port clock, input, 1: the single system clock; all state is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: high while the game is in the ATAQUE state.
REQ-007 SHALL have port tiro, input, 1: one-clock pulse marking a confirmed attack.
REQ-008 SHALL have port acerto, input, 1: hit flag, valid only in the cycle tiro is high.
REQ-009 SHALL have port digito, output, 4: active-low digit selects; bit0 is the rightmost digit.
REQ-010 SHALL have port segmentos, output, 7: active-low segments; bit6 is a and bit0 is g.
REQ-011 SHALL have port dp, output, 1: active-low decimal point.
REQ-012 SHALL have port fim_jogo, output, 1: high in VITORIA or DERROTA.
REQ-013 SHALL have port vitoria, output, 1: high only in VITORIA.

Function
REQ-014 SHALL implement FSM states OCIOSO, JOGANDO, VITORIA and DERROTA.
REQ-015 SHALL move from OCIOSO to JOGANDO on the first clock with enable=1, loading acertos=00 and restantes=MAX_TIROS in that same clock.
REQ-016 SHALL, in any state, move to OCIOSO on the next clock when enable=0; counters SHALL hold their values.
REQ-017 SHALL, in JOGANDO, on tiro=1, decrement restantes by 1 and increment acertos by 1 when acerto=1; both counters SHALL be visible one clock after tiro.
REQ-018 SHALL hold both counters as 2-digit BCD (tens and units), using a borrow from units 0 to 9 on decrement and a carry from units 9 to 0 on increment.
REQ-019 SHALL move JOGANDO to VITORIA in the clock in which acertos reaches TOTAL_ALVOS.
REQ-020 SHALL move JOGANDO to DERROTA in the clock in which restantes reaches 00 and acertos is below TOTAL_ALVOS; when both occur on the same tiro, VITORIA SHALL win.
REQ-021 SHALL ignore tiro in OCIOSO, VITORIA and DERROTA, and SHALL ignore acerto whenever tiro=0.
REQ-022 SHALL use a free-running scan counter of DIV_BITS+2 bits whose top 2 bits select the active digit, asserting exactly one digito bit low at a time.
REQ-023 SHALL show digits 3..0 as acertos tens, acertos units, restantes tens and restantes units, with an active-low encoding where 0 = 0000001.
REQ-024 SHALL blank the display in OCIOSO, driving digito=1111, segmentos=1111111 and dp=1.
REQ-025 SHALL drive dp low on the active digit in VITORIA only, and dp=1 in every other state.
REQ-026 SHALL make fim_jogo and vitoria registered decodes of the state.

Reset
REQ-027 SHALL, on reset, immediately set state=OCIOSO, counters=00, scan counter=0, digito=1111, segmentos=1111111, dp=1, fim_jogo=0 and vitoria=0.
REQ-028 SHALL, when reset is asserted mid-game, discard the game; after release, a new game SHALL start only through REQ-015.

Configuration
REQ-029 SHALL, with macro PISCAR_FIM_EN defined, blank the display in VITORIA and DERROTA whenever bit DIV_BITS+7 of an extended scan counter is 1 (a blink), with fim_jogo and vitoria unaffected; without the macro, the display SHALL be steady in the end states and the extension bits SHALL be absent.

Verification
REQ-030 SHALL cover: reset asserted with enable=1 -> digito=1111, fim_jogo=0; after release, JOGANDO with display digits "0015".
REQ-031 SHALL cover: JOGANDO, three tiro pulses with acerto=1,0,1 -> acertos=02, restantes=12, with the units borrow exercised at 10->09 in a separate run.
REQ-032 SHALL cover: TOTAL_ALVOS=2 and MAX_TIROS=2, two hits -> VITORIA, vitoria=1, dp low, and a further tiro leaves the counters unchanged.
REQ-033 SHALL cover: MAX_TIROS=1, TOTAL_ALVOS=1, one tiro with acerto=1 -> VITORIA, not DERROTA; the same with acerto=0 -> DERROTA, fim_jogo=1, vitoria=0.
REQ-034 SHALL cover: DIV_BITS=2 -> digito cycles 1110, 1101, 1011, 0111 every 4 clocks; enable=0 -> blank on the next clock; enable=1 again -> counters reload.
REQ-035 SHALL cover, with PISCAR_FIM_EN defined and the game in DERROTA, alternating blank and shown windows of 2^(DIV_BITS+7) clocks.
